accelbrot_com_burst_drain: RTL and testbench

//  Read-side master for accelbrot_com_ram_fifo. Watches the FIFO's readable count and

---
 rtl/accelbrot_com_pkg.sv | 5 +
 rtl/accelbrot_com_reg_slice.sv | 24 ++
 rtl/accelbrot_com_burst_drain.sv | 94 +++++++++
 tb/tb_accelbrot_com_burst_drain.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/accelbrot_com_pkg.sv
// accelbrot_com_pkg: shared types and constants for the accelbrot_com blocks
package accelbrot_com_pkg;
  typedef enum logic [1:0] {IDLE, REQ, DATA, SETTLE} burst_drain_state_t;
  localparam int RAM_RD_LATENCY = 2;
endpackage

// File: rtl/accelbrot_com_reg_slice.sv
// accelbrot_com_reg_slice: 1-entry valid/ready register stage, holds its word until accepted
module accelbrot_com_reg_slice #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  assign in_ready = !out_valid || out_ready;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/accelbrot_com_burst_drain.sv
// accelbrot_com_burst_drain: cuts the FIFO read stream into length-requested bursts with a last flag
module accelbrot_com_burst_drain
  import accelbrot_com_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int SIZE_WIDTH = $clog2(DEPTH + 1),
  parameter int BURST_LEN  = 8,
  parameter int LEN_WIDTH  = $clog2(BURST_LEN + 1),
  parameter int TIMEOUT    = 64,
  parameter int SETTLE_CYC = RAM_RD_LATENCY + 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  flush,
  input  logic [SIZE_WIDTH-1:0] fifo_readable,
  output logic                  fifo_rd_ready,
  input  logic                  fifo_rd_valid,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [LEN_WIDTH-1:0]  req_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);
  localparam int IW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  localparam int SW = $clog2(SETTLE_CYC + 2);
  localparam logic [SIZE_WIDTH-1:0] FULL_R = SIZE_WIDTH'(BURST_LEN);
  localparam logic [IW-1:0] TO = IW'(TIMEOUT);
  localparam logic [SW-1:0] SLAST = SW'(SETTLE_CYC > 0 ? SETTLE_CYC - 1 : 0);
  burst_drain_state_t state;
  logic [IW-1:0] idle_cnt;
  logic [SW-1:0] settle_cnt;
  logic [LEN_WIDTH-1:0] pull_cnt, send_cnt;
  logic flush_pending, slice_ready, full, partial, timed_out, issue, fifo_hs, out_hs;
  assign fifo_rd_ready = pull_cnt != '0 && slice_ready;
  assign fifo_hs = fifo_rd_ready && fifo_rd_valid;
  assign out_hs = out_valid && out_ready;
  assign out_last = out_valid && send_cnt == LEN_WIDTH'(1);
  assign busy = state != IDLE || flush_pending;
  assign full = fifo_readable >= FULL_R;
  assign partial = fifo_readable != '0 && !full;
  assign timed_out = TIMEOUT != 0 && idle_cnt == TO;
  assign issue = state == IDLE && (full || (partial && (flush_pending || timed_out)));
  accelbrot_com_reg_slice #(.W(DATA_WIDTH)) u_out (
    .clk(clk), .rstn(rstn),
    .in_valid(fifo_rd_valid && pull_cnt != '0), .in_ready(slice_ready), .in_data(fifo_rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );
  // an issued burst always clears a pending flush, even one arriving in the same cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      idle_cnt      <= '0;
      settle_cnt    <= '0;
      pull_cnt      <= '0;
      send_cnt      <= '0;
      flush_pending <= 1'b0;
      req_valid     <= 1'b0;
      req_len       <= '0;
    end else begin
      flush_pending <= issue ? 1'b0 : flush || (flush_pending && !(state == IDLE && fifo_readable == '0));
      idle_cnt <= (state == IDLE && partial && !issue) ? (idle_cnt == TO ? idle_cnt : idle_cnt + 1'b1) : '0;
      case (state)
        IDLE: if (issue) begin
          state     <= REQ;
          req_valid <= 1'b1;
          req_len   <= full ? LEN_WIDTH'(BURST_LEN) : LEN_WIDTH'(fifo_readable);
        end
        REQ: if (req_ready) begin
          state     <= DATA;
          req_valid <= 1'b0;
          pull_cnt  <= req_len;
          send_cnt  <= req_len;
        end
        DATA: begin
          if (fifo_hs) pull_cnt <= pull_cnt - 1'b1;
          if (out_hs) send_cnt <= send_cnt - 1'b1;
          if (out_hs && send_cnt == LEN_WIDTH'(1)) begin
            state      <= SETTLE;
            settle_cnt <= '0;
          end
        end
        SETTLE: begin
          settle_cnt <= settle_cnt + 1'b1;
          if (settle_cnt >= SLAST) state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_accelbrot_com_burst_drain.sv
// tb_accelbrot_com_burst_drain: burst drain behind a behavioural FIFO with 2-cycle readable lag
module tb_accelbrot_com_burst_drain;
  typedef struct {
    int    n;
    bit    fl;
    bit    rnd;
    bit    dly;
    int    lo;
    int    hi;
    string name;
  } vec_t;
  logic clk = 0, rstn = 0, flush = 0;
  logic [4:0] fifo_readable;
  logic fifo_rd_ready, fifo_rd_valid;
  logic [31:0] fifo_rd_data;
  logic req_valid, req_ready = 1;
  logic [3:0] req_len;
  logic out_valid, out_ready = 1;
  logic [31:0] out_data;
  logic out_last, busy;
  always #5 clk = ~clk;
  accelbrot_com_burst_drain #(
    .DATA_WIDTH(32), .DEPTH(16), .BURST_LEN(8), .TIMEOUT(64)
  ) dut (
    .clk(clk), .rstn(rstn), .flush(flush), .fifo_readable(fifo_readable),
    .fifo_rd_ready(fifo_rd_ready), .fifo_rd_valid(fifo_rd_valid), .fifo_rd_data(fifo_rd_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_len(req_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );
  // FIFO model: count is visible on fifo_readable two cycles late
  logic wr_en = 0;
  logic [31:0] wr_data = 0;
  logic [31:0] mem [16];
  logic [3:0] wp, rp;
  logic [4:0] cnt, r1, r2;
  logic do_push, do_pop;
  assign do_pop = fifo_rd_ready && fifo_rd_valid;
  assign do_push = wr_en && cnt != 5'd16;
  assign fifo_rd_valid = cnt != 0;
  assign fifo_rd_data = mem[rp];
  assign fifo_readable = r2;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp <= 0; rp <= 0; cnt <= 0; r1 <= 0; r2 <= 0;
    end else begin
      if (do_push) begin
        mem[wp] <= wr_data;
        wp <= wp + 1'b1;
      end
      if (do_pop) rp <= rp + 1'b1;
      cnt <= cnt + 5'(do_push) - 5'(do_pop);
      r1 <= cnt;
      r2 <= r1;
    end
  end
  int n_tests = 0, n_fail = 0, cyc = 0, rises = 0, rise_cyc = 0, beat = 0, blen = 0, rq_cnt = 0;
  bit rand_rdy = 0, req_delay = 0, p_ostall = 0, p_rstall = 0, p_rv = 0;
  logic [31:0] p_data;
  logic p_last;
  logic [3:0] p_len;
  logic [31:0] exp_data [$];
  int exp_len [$];
  vec_t tbl [6];
  task automatic chk(input bit ok, input string nm, input logic [31:0] a, input logic [31:0] e);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endtask
  function automatic bit all_zero();
    return !(req_valid | out_valid | out_last | fifo_rd_ready | busy) && req_len == 0 && out_data == 0;
  endfunction
  task automatic mon();
    logic [31:0] e;
    if (p_ostall) chk(out_valid && out_data == p_data && out_last == p_last, "out_hold", out_data, p_data);
    if (p_rstall) chk(req_valid && req_len == p_len, "req_hold", 32'(req_len), 32'(p_len));
    if (req_valid && !p_rv) begin
      rises++;
      rise_cyc = cyc;
    end
    if (req_valid && req_ready) begin
      if (exp_len.size() == 0) chk(0, "req_extra", 32'(req_len), 0);
      else begin
        e = 32'(exp_len.pop_front());
        chk(32'(req_len) == e, "req_len", 32'(req_len), e);
      end
      blen = int'(req_len);
      beat = 0;
    end
    if (out_valid && out_ready) begin
      beat++;
      if (exp_data.size() == 0) chk(0, "data_extra", out_data, 0);
      else begin
        e = exp_data.pop_front();
        chk(out_data == e, "data", out_data, e);
      end
      chk(out_last == (beat == blen), "last", 32'(out_last), 32'(beat == blen));
    end
    p_ostall = out_valid && !out_ready;
    p_data = out_data;
    p_last = out_last;
    p_rstall = req_valid && !req_ready;
    p_len = req_len;
    p_rv = req_valid;
  endtask
  // one clock: observe at negedge, then drive just after posedge
  task automatic tick();
    @(negedge clk);
    if (rstn) mon();
    @(posedge clk);
    cyc++;
    #1;
    out_ready = !rand_rdy || $urandom_range(0, 1) == 1;
    rq_cnt = req_valid ? rq_cnt + 1 : 0;
    req_ready = !req_delay || rq_cnt > 10;
  endtask
  task automatic push_words(input int n);
    for (int i = 0; i < n; i++) begin
      wr_en = 1;
      wr_data = $urandom;
      exp_data.push_back(wr_data);
      tick();
    end
    wr_en = 0;
  endtask
  task automatic run(input vec_t v);
    int r0, t0, d;
    r0 = rises;
    rand_rdy = v.rnd;
    req_delay = v.dly;
    for (int i = 0; i < v.n / 8; i++) exp_len.push_back(8);
    if (v.n % 8 != 0) exp_len.push_back(v.n % 8);
    push_words(v.n);
    t0 = cyc;
    if (v.fl) begin
      repeat (3) tick();
      flush = 1;
      tick();
      flush = 0;
      t0 = cyc;
    end
    for (int k = 0; k < 200 && rises == r0; k++) tick();
    d = rise_cyc - t0;
    chk(rises != r0 && d >= v.lo && d <= v.hi, {v.name, "_latency"}, d, v.lo);
    for (int k = 0; k < 600 && (exp_data.size() != 0 || exp_len.size() != 0 || busy); k++) tick();
    chk(exp_data.size() == 0 && exp_len.size() == 0 && !busy, {v.name, "_drain"}, exp_data.size(), 0);
    rand_rdy = 0;
    req_delay = 0;
  endtask
  initial begin
    int r0;
    tbl = '{'{16, 0, 0, 0, -8, -2, "full_2x8"},
            '{3,  0, 0, 0, 64, 67, "timeout_3"},
            '{5,  1, 0, 0, 1,  5,  "flush_5"},
            '{8,  0, 1, 1, 1,  5,  "stall_8"},
            '{1,  1, 0, 0, 1,  5,  "flush_1"},
            '{8,  0, 0, 0, 1,  5,  "post_reset_8"}};
    repeat (3) tick();
    chk(all_zero(), "reset_outputs", {req_valid, out_valid, fifo_rd_ready, busy}, 0);
    rstn = 1;
    tick();
    for (int i = 0; i < 5; i++) run(tbl[i]);
    r0 = rises;
    flush = 1;
    tick();
    flush = 0;
    chk(busy == 1, "flush_empty_pending", 32'(busy), 1);
    tick();
    chk(busy == 0, "flush_empty_idle", 32'(busy), 0);
    repeat (10) tick();
    chk(rises == r0, "flush_empty_noreq", rises, r0);
    exp_len.push_back(8);
    push_words(8);
    for (int k = 0; k < 100 && exp_data.size() > 5; k++) tick();
    chk(exp_data.size() == 5 && out_valid, "mid_burst_beats", exp_data.size(), 5);
    #2 rstn = 0;
    #1 chk(all_zero(), "async_reset", {req_valid, out_valid, fifo_rd_ready, busy}, 0);
    exp_data.delete();
    exp_len.delete();
    p_ostall = 0;
    p_rstall = 0;
    p_rv = 0;
    beat = 0;
    repeat (2) tick();
    rstn = 1;
    tick();
    run(tbl[5]);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
